// File: rtl/ex_mem_stage.sv
// ex_mem_stage: pipeline stage directly after the ALU.
// It captures the ALU result and the EX-side control into a 2-entry skid buffer.
// The buffer talks to the MEM stage through a valid/ready handshake.
// Branches and jumps are resolved when they are accepted, and each taken one
// produces a one-cycle redirect pulse toward fetch.
module ex_mem_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR   = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic [REG_ADDR-1:0]   rd,
    input  logic [5:0]            ctrl,
    input  logic                  flush,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [DATA_WIDTH-1:0] mem_alu,
    output logic [DATA_WIDTH-1:0] mem_sdata,
    output logic [REG_ADDR-1:0]   mem_rd,
    output logic [3:0]            mem_ctrl,
    output logic                  redirect,
    output logic [DATA_WIDTH-1:0] redirect_pc
);

    // Occupancy of the skid buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    // One buffered instruction as MEM sees it.
    // The Branch and Jump bits are consumed on accept and are not stored.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] alu;
        logic [DATA_WIDTH-1:0] sdata;
        logic [REG_ADDR-1:0]   rd;
        logic [3:0]            ctrl;   // {RegWrite, MemRead, MemWrite, MemToReg}
    } entry_t;

    state_e                state_q, state_d;
    entry_t                slot0_q, slot0_d;   // head, drives mem_*
    entry_t                slot1_q, slot1_d;   // second entry, only valid in TWO
    logic                  ex_ready_q, ex_ready_d;
    logic                  redirect_q, redirect_d;
    logic [DATA_WIDTH-1:0] redirect_pc_q, redirect_pc_d;

    logic                  accept;
    logic                  pop;
    logic                  is_jump;
    logic                  is_branch;
    logic                  taken;
    logic [DATA_WIDTH-1:0] link_value;
    entry_t                in_entry;

    assign accept     = ex_valid & ex_ready_q;
    assign pop        = mem_valid & mem_ready;
    assign is_jump    = ctrl[0];
    assign is_branch  = ctrl[1];
    assign taken      = is_jump | (is_branch & alu_result[0]);
    assign link_value = pc + DATA_WIDTH'(4);

    // Build the entry to store; a linking jump records the return address instead of the ALU result.
    always_comb begin
        in_entry.alu   = (is_jump & ctrl[5]) ? link_value : alu_result;
        in_entry.sdata = store_data;
        in_entry.rd    = rd;
        in_entry.ctrl  = ctrl[5:2];
    end

    // Next occupancy and slot contents; a flush overrides every transition and empties the buffer.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    slot0_d = in_entry;
                end
            end
            ONE: begin
                if (accept && !pop) begin
                    state_d = TWO;
                    slot1_d = in_entry;
                end else if (accept && pop) begin
                    slot0_d = in_entry;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    state_d = ONE;
                    slot0_d = slot1_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
        end
        ex_ready_d = (state_d != TWO);
    end

    // Redirect pulse for a taken branch or jump; the target is held until the next taken accept.
    always_comb begin
        redirect_d    = accept & taken & ~flush;
        redirect_pc_d = redirect_d ? (pc + imm) : redirect_pc_q;
    end

    // State, slot and redirect registers.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the two slots are reset too, because the data outputs must read 0 out of reset.
        if (reset) begin
            state_q       <= EMPTY;
            slot0_q       <= '0;
            slot1_q       <= '0;
            ex_ready_q    <= 1'b1;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q       <= state_d;
            slot0_q       <= slot0_d;
            slot1_q       <= slot1_d;
            ex_ready_q    <= ex_ready_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign ex_ready    = ex_ready_q;
    assign mem_valid   = (state_q != EMPTY);
    assign mem_alu     = slot0_q.alu;
    assign mem_sdata   = slot0_q.sdata;
    assign mem_rd      = slot0_q.rd;
    assign mem_ctrl    = mem_valid ? slot0_q.ctrl : 4'b0000;
    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;

endmodule
